// File: rtl/pixel_frame_loader.sv
// Framed pixel stream loader: quantizes 8-bit beats to 4 bits into a
// 784-entry frame buffer, pulses net_start, holds frame until net_done.
// Ports: clk, rst (async active-low), s_valid/s_data/s_last/s_ready
// stream in; rd_addr/rd_q sync read port (1-cycle latency); net_start,
// net_done, busy, frame_err, frame_cnt status.
// Option: define PIX_LOADER_ROUND_EN for round-to-nearest quantization.
module pixel_frame_loader #(
  parameter int NUM_PIXELS = 784,
  parameter int PIX_IN_W   = 8,
  parameter int PIX_OUT_W  = 4,
  parameter int ADDR_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [PIX_IN_W-1:0]  s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [PIX_OUT_W-1:0] rd_q,
  output logic                 net_start,
  input  logic                 net_done,
  output logic                 busy,
  output logic                 frame_err,
  output logic [7:0]           frame_cnt
);

  localparam int SHIFT = PIX_IN_W - PIX_OUT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_BUSY,
    S_DRAIN
  } state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_wr_ptr;
  logic                 r_s_ready;
  logic                 r_busy;
  logic                 r_net_start;
  logic                 r_frame_err;
  logic [7:0]           r_frame_cnt;
  logic [PIX_OUT_W-1:0] r_rd_q;
  logic [PIX_OUT_W-1:0] r_buf [NUM_PIXELS];

  logic                 w_accept;
  logic                 w_last_pix;
  logic                 w_wr_en;
  logic                 w_rd_ok;
  logic [PIX_OUT_W-1:0] w_q;

  assign w_accept   = s_valid & r_s_ready;
  assign w_last_pix = (r_wr_ptr == LAST_ADDR);
  assign w_wr_en    = (r_state == S_FILL) & w_accept;
  assign w_rd_ok    = (32'(rd_addr) < NUM_PIXELS);

`ifdef PIX_LOADER_ROUND_EN
  localparam logic [PIX_IN_W:0] HALF =
    (PIX_IN_W+1)'(1) << (SHIFT - 1);
  localparam logic [PIX_IN_W:0] QMAX =
    (PIX_IN_W+1)'((1 << PIX_OUT_W) - 1);

  logic [PIX_IN_W:0] w_sum;
  logic [PIX_IN_W:0] w_sh;

  // Extra top bit keeps the carry of 0xF8+8 so it saturates, not wraps.
  assign w_sum = {1'b0, s_data} + HALF;
  assign w_sh  = w_sum >> SHIFT;
  assign w_q   = (w_sh > QMAX) ? PIX_OUT_W'(QMAX)
                               : PIX_OUT_W'(w_sh);
`else
  assign w_q = PIX_OUT_W'(s_data >> SHIFT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_net_start <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_net_start <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state   <= S_FILL;
          r_s_ready <= 1'b1;
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_pix) begin
              r_wr_ptr <= '0;
              if (s_last) begin
                r_state     <= S_START;
                r_s_ready   <= 1'b0;
                r_net_start <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end else begin
                r_state     <= S_DRAIN;
                r_frame_err <= 1'b1;
              end
            end else if (s_last) begin
              r_wr_ptr    <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_accept && s_last)
            r_state <= S_FILL;
        end
        S_START: begin
          r_state <= S_BUSY;
          r_busy  <= 1'b1;
        end
        S_BUSY: begin
          if (net_done) begin
            r_state   <= S_FILL;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b1;
            r_wr_ptr  <= '0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_buf[r_wr_ptr] <= w_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rd_q <= '0;
    else
      r_rd_q <= w_rd_ok ? r_buf[rd_addr] : '0;
  end

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign net_start = r_net_start;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign rd_q      = r_rd_q;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Testbench for pixel_frame_loader: random framed streams checked
// against a frame-level reference buffer model.
module tb_pixel_frame_loader;

  localparam int NP   = 784;
  localparam int PIN  = 8;
  localparam int POUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [9:0] rd_addr = '0;
  logic [3:0] rd_q;
  logic       net_start;
  logic       net_done = 1'b0;
  logic       busy;
  logic       frame_err;
  logic [7:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int ns_cnt = 0;
  int fe_cnt = 0;
  int mb [NP];
  logic [7:0] fd [800];

  pixel_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .rd_addr   (rd_addr),
    .rd_q      (rd_q),
    .net_start (net_start),
    .net_done  (net_done),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (net_start) ns_cnt++;
    if (frame_err) fe_cnt++;
  end

  function automatic int qref(int d);
    int step;
    int q;
    step = 1 << (PIN - POUT);
`ifdef PIX_LOADER_ROUND_EN
    q = (d + step / 2) / step;
    if (q > (1 << POUT) - 1) q = (1 << POUT) - 1;
`else
    q = d / step;
`endif
    return q;
  endfunction

  task automatic push(input logic [7:0] d, input logic l);
    int t;
    if ($urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    t = 0;
    while (!s_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL push_timeout s_ready=%0b required=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // mode 0: i[7:0], 1: random, 2: constant 0x08
  task automatic send_frame(input int n, input int last_at,
                            input int mode);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       fd[i] = 8'(i);
        1:       fd[i] = 8'($urandom);
        default: fd[i] = 8'h08;
      endcase
      push(fd[i], i == last_at);
    end
  endtask

  task automatic read_buf(input int a, output logic [3:0] q);
    rd_addr = 10'(a);
    @(negedge clk);
    q = rd_q;
  endtask

  task automatic sweep(input string tag);
    logic [3:0] q;
    for (int a = 0; a < NP; a++) begin
      read_buf(a, q);
      if (mb[a] >= 0) begin
        checks++;
        if (q !== 4'(mb[a])) begin
          failures++;
          $display("FAIL %s addr=%0d rd_q=%0h required=%0h",
                   tag, a, q, mb[a]);
        end
      end
    end
  endtask

  task automatic pulse_done();
    net_done = 1'b1;
    @(negedge clk);
    net_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, busy, net_start, frame_err} !== 4'b0 ||
        frame_cnt !== 8'd0 || rd_q !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs rdy=%b busy=%b ns=%b fe=%b cnt=%0d q=%0h required=all 0",
               s_ready, busy, net_start, frame_err, frame_cnt, rd_q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early s_ready=%b required=0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_ready_rise s_ready=%b cnt=%0d required=1,0",
               s_ready, frame_cnt);
    end
  endtask

  task automatic test_full_frame();
    int ns0;
    logic [3:0] q;
    ns0 = ns_cnt;
    send_frame(NP, NP - 1, 0);
    checks++;
    if (net_start !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_start ns=%b busy=%b rdy=%b required=1,0,0",
               net_start, busy, s_ready);
    end
    @(negedge clk);
    checks++;
    if (net_start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_busy ns=%b busy=%b required=0,1",
               net_start, busy);
    end
    checks++;
    if (ns_cnt - ns0 != 1 || frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL full_count pulses=%0d cnt=%0d required=1,1",
               ns_cnt - ns0, frame_cnt);
    end
    for (int i = 0; i < NP; i++) mb[i] = qref(int'(fd[i]));
    read_buf(100, q);
    checks++;
    if (q !== 4'(qref(100))) begin
      failures++;
      $display("FAIL full_addr100 rd_q=%0h required=%0h", q, qref(100));
    end
    read_buf(783, q);
    checks++;
    if (q !== 4'(qref(783 % 256))) begin
      failures++;
      $display("FAIL full_addr783 rd_q=%0h required=%0h",
               q, qref(783 % 256));
    end
    read_buf(1000, q);
    checks++;
    if (q !== 4'd0) begin
      failures++;
      $display("FAIL full_oob rd_q=%0h required=0", q);
    end
    sweep("full_sweep");
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      @(negedge clk);
      if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stall bad_cycles=%0d required=0", bad);
    end
    sweep("bp_unchanged");
    pulse_done();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_release rdy=%b busy=%b required=1,0",
               s_ready, busy);
    end
    pulse_done();
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_done_ignored rdy=%b busy=%b required=1,0",
               s_ready, busy);
    end
    send_frame(NP, NP - 1, 1);
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_second cnt=%0d busy=%b required=2,1",
               frame_cnt, busy);
    end
    for (int i = 0; i < NP; i++) mb[i] = qref(int'(fd[i]));
    sweep("bp_sweep");
    pulse_done();
  endtask

  task automatic test_short_frame();
    int ns0;
    int fe0;
    ns0 = ns_cnt;
    fe0 = fe_cnt;
    send_frame(100, 99, 1);
    checks++;
    if (frame_err !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL short_err fe=%b rdy=%b required=1,1",
               frame_err, s_ready);
    end
    for (int i = 0; i < 100; i++) mb[i] = qref(int'(fd[i]));
    @(negedge clk);
    checks++;
    if (fe_cnt - fe0 != 1 || ns_cnt != ns0) begin
      failures++;
      $display("FAIL short_pulses fe=%0d ns=%0d required=1,0",
               fe_cnt - fe0, ns_cnt - ns0);
    end
    send_frame(NP, NP - 1, 1);
    checks++;
    if (net_start !== 1'b1) begin
      failures++;
      $display("FAIL short_recover ns=%b required=1", net_start);
    end
    @(negedge clk);
    for (int i = 0; i < NP; i++) mb[i] = qref(int'(fd[i]));
    sweep("short_sweep");
    pulse_done();
  endtask

  task automatic test_long_frame();
    int ns0;
    int fe0;
    ns0 = ns_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 800; i++) begin
      fd[i] = 8'($urandom);
      push(fd[i], i == 799);
      if (i == NP - 1) begin
        checks++;
        if (frame_err !== 1'b1) begin
          failures++;
          $display("FAIL long_err fe=%b required=1", frame_err);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (fe_cnt - fe0 != 1 || ns_cnt != ns0 ||
        s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL long_state fe=%0d ns=%0d rdy=%b busy=%b required=1,0,1,0",
               fe_cnt - fe0, ns_cnt - ns0, s_ready, busy);
    end
    for (int i = 0; i < NP; i++) mb[i] = qref(int'(fd[i]));
    sweep("long_drop");
    send_frame(NP, NP - 1, 1);
    checks++;
    if (net_start !== 1'b1) begin
      failures++;
      $display("FAIL long_recover ns=%b required=1", net_start);
    end
    @(negedge clk);
    for (int i = 0; i < NP; i++) mb[i] = qref(int'(fd[i]));
    sweep("long_sweep");
    pulse_done();
  endtask

  task automatic test_reset_mid_fill();
    int ns0;
    int fe0;
    logic [3:0] q;
    int a;
    send_frame(400, -1, 1);
    ns0 = ns_cnt;
    fe0 = fe_cnt;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd0 || s_ready !== 1'b0 || rd_q !== 4'd0) begin
      failures++;
      $display("FAIL midrst_state cnt=%0d rdy=%b q=%0h required=0,0,0",
               frame_cnt, s_ready, rd_q);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ns_cnt != ns0 || fe_cnt != fe0) begin
      failures++;
      $display("FAIL midrst_pulses ns=%0d fe=%0d required=0,0",
               ns_cnt - ns0, fe_cnt - fe0);
    end
    send_frame(NP, NP - 1, 2);
    checks++;
    if (net_start !== 1'b1) begin
      failures++;
      $display("FAIL midrst_frame ns=%b required=1", net_start);
    end
    @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL midrst_cnt cnt=%0d required=1", frame_cnt);
    end
    for (int k = 0; k < 12; k++) begin
      a = (k == 0) ? 0 : (k == 1) ? NP - 1 : $urandom_range(0, NP - 1);
      read_buf(a, q);
      checks++;
      if (q !== 4'(qref(8))) begin
        failures++;
        $display("FAIL round_q addr=%0d rd_q=%0h required=%0h",
                 a, q, qref(8));
      end
    end
    pulse_done();
  endtask

  initial begin
    for (int i = 0; i < NP; i++) mb[i] = -1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
